// File: rtl/bit_stuff_tx.sv
// Byte-to-serial transmitter with run-length bit stuffing.
// Each accepted byte is sent LSB first on w. After RUN_MAX identical bits
// in a row, a complementary stuff bit is inserted so the line never holds
// one level longer than RUN_MAX bits. Stuff bits take part in run tracking
// just like data bits. Run history starts afresh with every frame.
module bit_stuff_tx #(
    parameter int RUN_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       w,
    output logic       w_valid,
    output logic       frame_done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    // The run counter is 3 bits wide because RUN_MAX never exceeds 7.
    localparam logic [2:0] RUN_LIM = RUN_MAX[2:0];

    fsm_t       fsm;
    logic [7:0] shreg;     // remaining data bits, bit 0 is the one on w in SEND
    logic [3:0] idx;       // number of data bits already emitted
    logic [2:0] run;       // length of the current run; 0 means no bit sent yet
    logic       last_bit;  // value of the most recently emitted bit
    logic       bit_now;
    logic [2:0] run_next;

    assign state = fsm;

    // Run length that results from emitting the current data bit.
    always_comb begin
        bit_now  = shreg[0];
        run_next = 3'd1;
        if ((run != 3'd0) && (bit_now == last_bit)) begin
            run_next = run + 3'd1;
        end
    end

    // Frame sequencer. Outputs are registered and change together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= IDLE;
            shreg      <= 8'd0;
            idx        <= 4'd0;
            run        <= 3'd0;
            last_bit   <= 1'b0;
            din_ready  <= 1'b1;
            w          <= 1'b0;
            w_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (din_valid) begin
                        fsm       <= SEND;
                        shreg     <= din;
                        idx       <= 4'd0;
                        run       <= 3'd0;
                        last_bit  <= 1'b0;
                        din_ready <= 1'b0;
                        w         <= din[0];
                        w_valid   <= 1'b1;
                    end
                end

                SEND: begin
                    shreg    <= {1'b0, shreg[7:1]};
                    idx      <= idx + 4'd1;
                    last_bit <= bit_now;
                    run      <= run_next;
                    if (run_next == RUN_LIM) begin
                        // Run reached the limit: force the opposite level next.
                        fsm     <= STUFF;
                        w       <= ~bit_now;
                        w_valid <= 1'b1;
                    end else if (idx == 4'd7) begin
                        fsm        <= DONE;
                        w          <= 1'b0;
                        w_valid    <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        w       <= shreg[1];
                        w_valid <= 1'b1;
                    end
                end

                STUFF: begin
                    // The stuff bit on w starts a new run of length one.
                    last_bit <= w;
                    run      <= 3'd1;
                    if (idx == 4'd8) begin
                        fsm        <= DONE;
                        w          <= 1'b0;
                        w_valid    <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        fsm     <= SEND;
                        w       <= shreg[0];
                        w_valid <= 1'b1;
                    end
                end

                DONE: begin
                    fsm        <= IDLE;
                    frame_done <= 1'b0;
                    din_ready  <= 1'b1;
                    w          <= 1'b0;
                    w_valid    <= 1'b0;
                end

                default: begin
                    fsm        <= IDLE;
                    din_ready  <= 1'b1;
                    w          <= 1'b0;
                    w_valid    <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bit_stuff_tx.md
BIT_STUFF_TX -- requirements
Module: bit_stuff_tx

Interface
REQ-001 Parameter RUN_MAX, default 3, is the longest run of identical bits allowed on w before a complementary stuff bit is forced; legal range 2..7.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 din  input  8  byte to serialise, sampled on handshake.
REQ-005 din_valid  input  1  din holds a byte to send.
REQ-006 din_ready  output  1  block can accept a byte this cycle.
REQ-007 w  output  1  serial bit stream, LSB first, stuff bits inserted.
REQ-008 w_valid  output  1  w carries a data or stuff bit this cycle.
REQ-009 frame_done  output  1  one-cycle pulse after the last bit of a frame.
REQ-010 state  output  2  debug encoding of the current FSM state.

Function
REQ-011 The FSM SHALL have four states: IDLE=0, SEND=1, STUFF=2, DONE=3.
REQ-012 In IDLE the outputs SHALL be din_ready=1, w_valid=0, w=0 and frame_done=0.
REQ-013 A handshake SHALL occur on a rising edge where din_valid=1 and din_ready=1; on that edge the block latches din, clears the data-bit index, clears the run counter and clears the last-bit record, then enters SEND.
REQ-014 din_ready SHALL be 1 only in IDLE; din_valid in any other state SHALL be ignored.
REQ-015 In SEND, w SHALL equal the next data bit, LSB first, with w_valid=1 and exactly one bit per cycle.
REQ-016 Run tracking SHALL work as follows:
- if the emitted bit equals the previous bit of the same frame, the run counter increments;
- otherwise the run counter becomes 1;
- the first bit of a frame sets the run counter to 1.
REQ-017 When the bit emitted in SEND brings the run counter to RUN_MAX, the next cycle SHALL be STUFF, in which w is the complement of that bit and w_valid=1.
REQ-018 A stuff bit SHALL set the run counter to 1 and the last-bit record to its own value; stuff bits count toward runs exactly like data bits.
REQ-019 A stuff bit SHALL also be inserted after the 8th data bit if that bit reached RUN_MAX.
REQ-020 After the 8th data bit, or its trailing stuff bit, the FSM SHALL enter DONE for exactly one cycle with frame_done=1, w_valid=0 and w=0, then return to IDLE.
REQ-021 The first bit of a frame SHALL appear in the cycle after the handshake edge.
REQ-022 Frame length SHALL be 8..11 bits for RUN_MAX=3.
REQ-023 Back-to-back minimum spacing SHALL be one DONE cycle plus one IDLE cycle between frames.
REQ-024 w SHALL never carry more than RUN_MAX consecutive identical bits within a frame.
REQ-025 Run history SHALL NOT carry across frames.
REQ-026 state SHALL reflect the registered FSM state in the same cycle.

Reset
REQ-027 While reset=1 at a rising edge, the block SHALL enter IDLE, clear the shift register, data-bit index, run counter and last-bit record, and ignore din_valid.
REQ-028 After the reset edge the outputs SHALL be din_ready=1, w_valid=0, w=0, frame_done=0 and state=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame without asserting frame_done; the partial frame is discarded.
REQ-030 Reset SHALL take priority over a simultaneous handshake.

Verification
REQ-031 Test 1, din=0x55 with RUN_MAX=3 -> w=1,0,1,0,1,0,1,0 on cycles +1..+8 with w_valid=1; frame_done on +9; din_ready=1 on +10.
REQ-032 Test 2, din=0x00 -> 10 bits: w=0,0,0,1,0,0,0,1,0,0, with state=2 on cycles +4 and +8; frame_done on +11.
REQ-033 Test 3, din=0x07 -> 11 bits: w=1,1,1,0,0,0,1,0,0,0,1 (trailing stuff bit); frame_done on +12.
REQ-034 Test 4, din_valid held high with 0xFF then 0x55 -> first frame w=1,1,1,0,1,1,1,0,1,1; second byte accepted on the IDLE cycle after DONE; din_valid ignored during the frame.
REQ-035 Test 5, reset asserted on cycle +4 of a 0x00 frame -> next cycle w_valid=0, state=0, din_ready=1, no frame_done; a new 0x00 frame then reproduces Test 2 exactly.
REQ-036 Test 6, random bytes with RUN_MAX=2 and 3 -> a scoreboard removes stuff bits and matches the data, and no run on w exceeds RUN_MAX.
